// File: rtl/sram_1w1r_param.sv
// sram_1w1r_param: parametrised single-clock 1W1R synchronous SRAM model.
//
// Successor to the fixed 320x11 store. Supports lane write masks, a defined
// same-address read-during-write result, an optional output register,
// out-of-range detection and a read-valid strobe.
//
// Ports:
//   clk_i        clock, all state updates on posedge
//   rst_ni       synchronous active-low reset (clears read pipeline, not the array)
//   wr_en_i      write request
//   wr_addr_i    write address
//   wr_data_i    write data
//   wr_mask_i    lane enables, bit k covers bits [k*LW +: LW]
//   rd_en_i      read request
//   rd_addr_i    read address
//   rd_data_o    read data, held until the next read completes
//   rd_valid_o   one-cycle pulse when rd_data_o carries a read result
//   rd_oob_o     with rd_valid_o: read address was >= DEPTH
//   collision_o  with rd_valid_o: read hit the address written in the same cycle
`timescale 1ns / 1ps

module sram_1w1r_param #(
  parameter int unsigned DATA_WIDTH = 11,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DEPTH      = 320,
  parameter int unsigned MASK_WIDTH = 1,
  parameter bit          RDW_MODE   = 1'b0,
  parameter bit          OUT_REG    = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [MASK_WIDTH-1:0] wr_mask_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  rd_oob_o,
  output logic                  collision_o
);

  localparam int unsigned Lw = DATA_WIDTH / MASK_WIDTH;
  localparam logic [ADDR_WIDTH:0] DepthLim = (ADDR_WIDTH + 1)'(DEPTH);

  if ((DATA_WIDTH % MASK_WIDTH) != 0) begin : g_bad_mask
    $fatal(1, "sram_1w1r_param: MASK_WIDTH must divide DATA_WIDTH");
  end
  if (longint'(DEPTH) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_depth
    $fatal(1, "sram_1w1r_param: DEPTH exceeds 2**ADDR_WIDTH");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] wr_bits;
  logic                  wr_hit;
  logic                  rd_in_range;
  logic                  collision;
  logic [DATA_WIDTH-1:0] rd_word;

  // Expand lane mask to a per-bit mask.
  for (genvar k = 0; k < MASK_WIDTH; k++) begin : g_lane
    assign wr_bits[k*Lw +: Lw] = {Lw{wr_mask_i[k]}};
  end

  assign wr_hit      = wr_en_i && ({1'b0, wr_addr_i} < DepthLim);
  assign rd_in_range = {1'b0, rd_addr_i} < DepthLim;
  // Equal addresses imply the write is in range too.
  assign collision   = rd_in_range && wr_en_i && (wr_addr_i == rd_addr_i);

  // Array is deliberately not reset; writes during reset are dropped.
  always_ff @(posedge clk_i) begin
    if (rst_ni && wr_hit) begin
      mem_q[wr_addr_i] <= (mem_q[wr_addr_i] & ~wr_bits) | (wr_data_i & wr_bits);
    end
  end

  // Old word by default; write-through merge only on a collision in RDW_MODE=1.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem_q[rd_addr_i];
      if (RDW_MODE && collision) begin
        rd_word = (rd_word & ~wr_bits) | (wr_data_i & wr_bits);
      end
    end
  end

  logic                  s1_valid_q, s1_oob_q, s1_coll_q;
  logic [DATA_WIDTH-1:0] s1_data_q;

  // First read stage; data only moves on a read so the output holds otherwise.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_oob_q   <= 1'b0;
      s1_coll_q  <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= rd_en_i;
      s1_oob_q   <= rd_en_i && !rd_in_range;
      s1_coll_q  <= rd_en_i && collision;
      if (rd_en_i) begin
        s1_data_q <= rd_word;
      end
    end
  end

  if (OUT_REG) begin : g_out_reg
    logic                  s2_valid_q, s2_oob_q, s2_coll_q;
    logic [DATA_WIDTH-1:0] s2_data_q;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        s2_valid_q <= 1'b0;
        s2_oob_q   <= 1'b0;
        s2_coll_q  <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        s2_oob_q   <= s1_oob_q;
        s2_coll_q  <= s1_coll_q;
        if (s1_valid_q) begin
          s2_data_q <= s1_data_q;
        end
      end
    end

    assign rd_data_o   = s2_data_q;
    assign rd_valid_o  = s2_valid_q;
    assign rd_oob_o    = s2_oob_q;
    assign collision_o = s2_coll_q;
  end else begin : g_no_out_reg
    assign rd_data_o   = s1_data_q;
    assign rd_valid_o  = s1_valid_q;
    assign rd_oob_o    = s1_oob_q;
    assign collision_o = s1_coll_q;
  end

endmodule

// File: tb/tb_sram_1w1r_param.sv
// Bench for sram_1w1r_param. Two instances share address/enable stimulus:
//   a: 11-bit, 1 lane, old-data on collision, latency 1
//   b: 16-bit, 2 lanes, write-through on collision, latency 2
// A reference model (plain arrays plus a table of results scheduled by due edge)
// predicts every output after every edge.
`timescale 1ns / 1ps

module tb_sram_1w1r_param;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, wr_en, rd_en;
  logic [8:0]  wr_addr, rd_addr;
  logic [10:0] wda;
  logic [15:0] wdb;
  logic [0:0]  wma;
  logic [1:0]  wmb;

  logic [10:0] rda_data;
  logic        rda_valid, rda_oob, rda_coll;
  logic [15:0] rdb_data;
  logic        rdb_valid, rdb_oob, rdb_coll;

  sram_1w1r_param #(
    .DATA_WIDTH(11), .ADDR_WIDTH(9), .DEPTH(320), .MASK_WIDTH(1), .RDW_MODE(1'b0), .OUT_REG(1'b0)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wda),
    .wr_mask_i(wma), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rda_data),
    .rd_valid_o(rda_valid), .rd_oob_o(rda_oob), .collision_o(rda_coll)
  );

  sram_1w1r_param #(
    .DATA_WIDTH(16), .ADDR_WIDTH(9), .DEPTH(320), .MASK_WIDTH(2), .RDW_MODE(1'b1), .OUT_REG(1'b1)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wdb),
    .wr_mask_i(wmb), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rdb_data),
    .rd_valid_o(rdb_valid), .rd_oob_o(rdb_oob), .collision_o(rdb_coll)
  );

  // Reference model state, index 0 = instance a, 1 = instance b.
  logic [15:0] mem_m [2][320];
  bit          pv [2][4];
  bit          po [2][4];
  bit          pc [2][4];
  logic [15:0] pd [2][4];
  logic [15:0] held [2];
  int          edge_cnt = 0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] merge(input int d, input logic [15:0] old,
                                        input logic [15:0] nw, input logic [1:0] m);
    logic [15:0] r;
    int lw, w;
    r  = old;
    lw = (d == 1) ? 8 : 11;
    w  = (d == 1) ? 16 : 11;
    for (int b = 0; b < w; b++) if (m[b / lw]) r[b] = nw[b];
    return r;
  endfunction

  // Apply the rules to the inputs about to be sampled at edge edge_cnt+1.
  task automatic model_pre();
    for (int d = 0; d < 2; d++) begin
      logic [15:0] wd;
      logic [1:0]  wm;
      int          slot;
      wd = (d == 1) ? wdb : {5'b0, wda};
      wm = (d == 1) ? wmb : {1'b0, wma};
      if (!rst_n) begin
        for (int s = 0; s < 4; s++) pv[d][s] = 1'b0;
        held[d] = '0;
      end else begin
        if (rd_en) begin
          slot        = (edge_cnt + 1 + d) % 4;
          pv[d][slot] = 1'b1;
          po[d][slot] = (rd_addr >= 9'd320);
          pc[d][slot] = !po[d][slot] && wr_en && (wr_addr == rd_addr);
          pd[d][slot] = po[d][slot] ? 16'h0 : mem_m[d][rd_addr];
          if (pc[d][slot] && d == 1) pd[d][slot] = merge(d, pd[d][slot], wd, wm);
        end
        if (wr_en && wr_addr < 9'd320) mem_m[d][wr_addr] = merge(d, mem_m[d][wr_addr], wd, wm);
      end
    end
  endtask

  task automatic check_post();
    for (int d = 0; d < 2; d++) begin
      int   slot;
      bit   ev, eo, ec;
      string p;
      slot = edge_cnt % 4;
      p    = (d == 1) ? "b" : "a";
      ev   = pv[d][slot];
      eo   = 1'b0;
      ec   = 1'b0;
      if (ev) begin
        held[d]     = pd[d][slot];
        eo          = po[d][slot];
        ec          = pc[d][slot];
        pv[d][slot] = 1'b0;
      end
      chk({p, "_valid"}, 32'((d == 1) ? rdb_valid : rda_valid), 32'(ev));
      chk({p, "_oob"}, 32'((d == 1) ? rdb_oob : rda_oob), 32'(eo));
      chk({p, "_coll"}, 32'((d == 1) ? rdb_coll : rda_coll), 32'(ec));
      chk({p, "_data"}, (d == 1) ? {16'h0, rdb_data} : {21'h0, rda_data}, {16'h0, held[d]});
    end
  endtask

  task automatic step();
    model_pre();
    @(posedge clk);
    #1;
    edge_cnt++;
    check_post();
  endtask

  task automatic drive(input bit we, input int wa, input logic [15:0] wd, input logic [1:0] mb,
                       input bit re, input int ra);
    wr_en   = we;
    wr_addr = 9'(wa);
    wda     = wd[10:0];
    wdb     = wd;
    wma     = 1'(mb != 2'b00);
    wmb     = mb;
    rd_en   = re;
    rd_addr = 9'(ra);
  endtask

  task automatic idle();
    drive(1'b0, 0, 16'h0, 2'b11, 1'b0, 0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      held[d] = '0;
      for (int s = 0; s < 4; s++) pv[d][s] = 1'b0;
    end

    // Reset held 3 clocks with reads requested: everything stays 0.
    rst_n = 1'b0;
    drive(1'b0, 0, 16'h0, 2'b11, 1'b1, 0);
    repeat (3) step();
    rst_n = 1'b1;

    // Fill the array so later reads are fully defined.
    for (int i = 0; i < 320; i++) begin
      drive(1'b1, i, 16'($urandom), 2'b11, 1'b0, 0);
      step();
    end
    drive(1'b0, 0, 16'h0, 2'b11, 1'b1, 0);
    step();
    idle();
    step();

    // Write then read back, latency 1 on a and 2 on b.
    drive(1'b1, 7, 16'h05A5, 2'b11, 1'b0, 0);
    step();
    drive(1'b0, 0, 16'h0, 2'b11, 1'b1, 7);
    step();
    chk("t2_a_data", {21'h0, rda_data}, 32'h5A5);
    chk("t2_a_valid", 32'(rda_valid), 32'd1);
    chk("t2_b_early", 32'(rdb_valid), 32'd0);
    idle();
    step();
    chk("t2_b_data", {16'h0, rdb_data}, 32'h05A5);
    chk("t2_b_valid", 32'(rdb_valid), 32'd1);

    // Lane mask: only the low lane of b changes.
    drive(1'b1, 3, 16'hFFFF, 2'b11, 1'b0, 0);
    step();
    drive(1'b1, 3, 16'h1234, 2'b01, 1'b0, 0);
    step();
    drive(1'b0, 0, 16'h0, 2'b11, 1'b1, 3);
    step();
    chk("t3_a_data", {21'h0, rda_data}, 32'h234);
    idle();
    step();
    chk("t3_b_data", {16'h0, rdb_data}, 32'hFF34);

    // Read during write to the same address.
    drive(1'b1, 9, 16'h0111, 2'b11, 1'b0, 0);
    step();
    drive(1'b1, 9, 16'h0222, 2'b11, 1'b1, 9);
    step();
    chk("t4_a_coll", 32'(rda_coll), 32'd1);
    chk("t4_a_data", {21'h0, rda_data}, 32'h111);
    idle();
    step();
    chk("t4_b_coll", 32'(rdb_coll), 32'd1);
    chk("t4_b_data", {16'h0, rdb_data}, 32'h0222);

    // Out of range write is dropped, out of range read flags oob with zero data.
    drive(1'b1, 318, 16'h0155, 2'b11, 1'b0, 0);
    step();
    drive(1'b1, 319, 16'h0066, 2'b11, 1'b0, 0);
    step();
    drive(1'b1, 320, 16'h03FF, 2'b11, 1'b0, 0);
    step();
    drive(1'b0, 0, 16'h0, 2'b11, 1'b1, 320);
    step();
    chk("t5_a_oob", 32'(rda_oob), 32'd1);
    chk("t5_a_data", {21'h0, rda_data}, 32'h0);
    drive(1'b0, 0, 16'h0, 2'b11, 1'b1, 319);
    step();
    chk("t5_b_oob", 32'(rdb_oob), 32'd1);
    chk("t5_b_data", {16'h0, rdb_data}, 32'h0);
    chk("t5_a_319", {21'h0, rda_data}, 32'h066);
    idle();
    step();
    chk("t5_b_319", {16'h0, rdb_data}, 32'h0066);

    // Randomized traffic with occasional resets, biased toward collisions.
    for (int i = 0; i < 2000; i++) begin
      rst_n   = ($urandom_range(99) != 0);
      wr_en   = 1'($urandom_range(1));
      rd_en   = ($urandom_range(3) != 0);
      wr_addr = ($urandom_range(1) == 1) ? 9'($urandom_range(7)) : 9'($urandom_range(335));
      if ($urandom_range(3) == 0) rd_addr = wr_addr;
      else rd_addr = ($urandom_range(1) == 1) ? 9'($urandom_range(7)) : 9'($urandom_range(335));
      wda = 11'($urandom);
      wdb = 16'($urandom);
      wma = 1'($urandom_range(1));
      wmb = 2'($urandom_range(3));
      step();
    end
    rst_n = 1'b1;
    idle();
    repeat (2) step();

    // Streaming reads with a reset pulse in the middle of the stream.
    for (int i = 0; i < 320; i++) begin
      rst_n = (i != 100);
      drive(1'b0, 0, 16'h0, 2'b11, 1'b1, i);
      step();
    end
    rst_n = 1'b1;
    idle();
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
